led_onehot_encoder: RTL and testbench
=====================================

# led_onehot_encoder

Front-panel input encoder: the reverse of the switch-to-LED decoder. It samples an 8-bit active-low one-hot pattern (`led = 8'hFF - (1 << code)`), debounces it, and encodes it back to a 3-bit code. Each stable change is reported once over a valid/ready handshake. Sits between the panel pins and the control logic that consumes switch codes.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is accepted; legal range 1..15.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: high = sampling and filtering run; low = filter frozen.
- `led` input 8: active-low pattern; bit i low means code i.
- `switch` output 3: encoded code; valid only while `valid` is high.
- `valid` output 1: event offered.
- `ready` input 1: consumer accepts the event when `valid && ready` at a rising edge.
- `none` output 1: qualifies `valid`; the event is all-off (`8'hFF`).
- `err` output 1: qualifies `valid`; the event has two or more low bits.

## Operation
- Sample register `s_q`: loads `led` every enabled edge.
- Stability counter `cnt`:
  - Cleared to 0 when `led != s_q` at the edge.
  - Otherwise increments, saturating at `STABLE_CYCLES-1`.
  - Width `$clog2(STABLE_CYCLES)`, minimum 1 bit.
- `stable` = `cnt == STABLE_CYCLES-1`.
- `last_q` holds the last reported pattern.
- Classification of `s_q`:
  - exactly one zero → `switch` = its index, `none`=0, `err`=0.
  - all ones → `switch`=0, `none`=1, `err`=0.
  - more than one zero → `switch`=0, `none`=0, `err`=1.
- FSM, two states:
  - TRACK: `valid`=0. If `enable && stable && s_q != last_q`, capture the classification into the output registers, set `last_q <= s_q`, and go to OFFER.
  - OFFER: `valid`=1 and outputs held constant. On `ready`, go to TRACK and drop `valid` at that edge.
- Sampling continues during OFFER, but no new event is generated until the FSM is back in TRACK. A pattern that changed and settled during OFFER is reported from TRACK on the first evaluation cycle.
- `enable`=0:
  - `s_q`, `cnt` and the TRACK→OFFER transition are frozen.
  - An event already in OFFER can still be accepted by `ready`.
- Reset values:
  - `s_q`=`8'hFF`, `last_q`=`8'hFF`, `cnt`=0, state TRACK.
  - `switch`=0, `valid`=0, `none`=0, `err`=0.
  - Consequence: an all-off panel after reset generates no event.
- `rst` overrides everything, including a pending OFFER; the event is discarded.

## Timing
- Latency: take edge 1 as the first edge that samples a new `led` value held steady. `valid` rises after edge `STABLE_CYCLES+1`. For the default, that is edge 5.
- A pattern that holds for fewer than `STABLE_CYCLES` samples produces no event.
- Each accepted event occupies at least 1 cycle in OFFER. With `ready` held high, back-to-back events have `valid` low for at least 1 cycle between them.
- `ready` may be asserted before `valid`. It has no effect in TRACK.
- Outputs are registered; there are no combinational paths from `led` or `ready` to any output.

## Structure
- Package `led_enc_pkg`:
  - state enum `{TRACK, OFFER}`.
  - constant `LED_ALL_OFF = 8'hFF`.
  - function `classify(8-bit) → {code, none, err}`, also reusable by the bench scoreboard.
- Sub-module `led_stability_filter`: `clk`, `rst`, `enable`, `led` in; `s_q` and `stable` out; parameter `STABLE_CYCLES`.
- The top holds the FSM, `last_q` and the output registers.

## Test plan
1. Reset, `led`=`8'hFF` for 20 cycles, `ready`=1 → `valid` never rises; `switch`, `none` and `err` stay 0.
2. `led`=`8'hF7` held, `ready`=1 → `valid` high for exactly 1 cycle after edge 5 with `switch`=3, `none`=0, `err`=0. Holding `8'hF7` for 30 further cycles produces no second event.
3. Glitch: `led`=`8'hEF` for 3 cycles, then back to `8'hFF` → no event. Then `8'hFE` held → event with `switch`=0.
4. Backpressure: `led`=`8'h7F`, `ready`=0 → `valid` holds with `switch`=7 for 10 cycles. Meanwhile `led`→`8'hFE` is held. Raise `ready` → `7` is accepted, `valid` is low for 1 cycle, then a new event with `switch`=0 appears.
5. Special patterns: `led`=`8'hF3` → event with `err`=1, `switch`=0. Then `led`=`8'hFF` → event with `none`=1. Sweep all 8 one-hot codes with random `ready` → each code is reported exactly once, in order.
6. Control and reset: `enable`=0 while `led` changes → no event until `enable` returns, and the event then arrives after full filtering. `rst` pulsed during OFFER → `valid` is 0 after that edge and all outputs return to reset values.

Source files
------------

// File: rtl/led_onehot_encoder_pkg.sv
// Shared types and the pattern classifier for the front-panel one-hot encoder.
// classify() is the single definition of how a sampled pattern maps to an event.
package led_enc_pkg;

    typedef enum logic {
        TRACK = 1'b0,
        OFFER = 1'b1
    } enc_state_t;

    localparam logic [7:0] LED_ALL_OFF = 8'hFF;

    typedef struct packed {
        logic [2:0] code;
        logic       none;
        logic       err;
    } led_class_t;

    // A single low bit yields its index. No low bits means all-off.
    // Two or more low bits is an error, and its code is forced to 0.
    function automatic led_class_t classify(input logic [7:0] pattern);
        led_class_t  c;
        int unsigned zeros;
        c     = '0;
        zeros = 0;
        for (int i = 0; i < 8; i++) begin
            if (!pattern[i]) begin
                zeros++;
                c.code = 3'(i);
            end
        end
        if (zeros == 0) begin
            c.none = 1'b1;
        end else if (zeros > 1) begin
            c.err  = 1'b1;
            c.code = 3'd0;
        end
        return c;
    endfunction

endpackage

// File: rtl/led_onehot_encoder_if.sv
// Event handshake between the panel encoder (master) and the switch-code consumer (slave).
interface led_onehot_encoder_if;
    logic [2:0] switch;
    logic       valid;
    logic       ready;
    logic       none;
    logic       err;

    modport master (output switch, output valid, output none, output err, input ready);
    modport slave  (input switch, input valid, input none, input err, output ready);
endinterface

// File: rtl/led_onehot_encoder_filter.sv
// Sampling register plus saturating stability counter for the panel pattern.
// The reset value of s_q counts as one all-off sample.
module led_stability_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] led,
    output logic [7:0] s_q,
    output logic       stable
);
    import led_enc_pkg::*;

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= LED_ALL_OFF;
            cnt <= '0;
        end else if (enable) begin
            s_q <= led;
            if (led != s_q) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign stable = (cnt == CNT_MAX);

endmodule

// File: rtl/led_onehot_encoder.sv
// Panel encoder top: debounced active-low one-hot input reported once per stable change.
// The report is made over a valid/ready handshake.
module led_onehot_encoder
    import led_enc_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [7:0]            led,
    led_onehot_encoder_if.master  bus
);

    logic [7:0] s_q;
    logic       stable;
    logic [7:0] last_q;
    enc_state_t state;
    led_class_t cls;

    led_stability_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .led    (led),
        .s_q    (s_q),
        .stable (stable)
    );

    assign cls = classify(s_q);

    // Outputs keep the last event's values after it is accepted; only valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TRACK;
            last_q     <= LED_ALL_OFF;
            bus.switch <= 3'd0;
            bus.valid  <= 1'b0;
            bus.none   <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            case (state)
                TRACK: begin
                    if (enable && stable && (s_q != last_q)) begin
                        state      <= OFFER;
                        last_q     <= s_q;
                        bus.switch <= cls.code;
                        bus.none   <= cls.none;
                        bus.err    <= cls.err;
                        bus.valid  <= 1'b1;
                    end
                end
                OFFER: begin
                    if (bus.ready) begin
                        state     <= TRACK;
                        bus.valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= TRACK;
                    bus.valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_onehot_encoder.sv
// Self-checking bench for led_onehot_encoder: directed scenarios plus random stimulus.
// A behavioural model built on a history of samples predicts every output.
module tb_led_onehot_encoder;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] led;

    int errors = 0;
    int checks = 0;

    led_onehot_encoder_if bus ();

    led_onehot_encoder #(.STABLE_CYCLES(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .led    (led),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a pattern is settled once the last N enabled samples agree.
    logic [7:0] hist[$];
    logic       m_offer;
    logic [2:0] m_sw;
    logic       m_none;
    logic       m_err;
    logic [7:0] m_last;
    logic [2:0] acc_q[$];

    function automatic bit settled();
        if (hist.size() < N) return 1'b0;
        foreach (hist[i]) if (hist[i] != hist[hist.size()-1]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            hist.push_back(8'hFF);
            m_offer = 1'b0;
            m_sw    = 3'd0;
            m_none  = 1'b0;
            m_err   = 1'b0;
            m_last  = 8'hFF;
        end else begin
            if (m_offer) begin
                if (bus.ready) m_offer = 1'b0;
            end else if (enable && settled() && hist[hist.size()-1] != m_last) begin
                logic [7:0] p;
                logic [7:0] lows;
                p    = hist[hist.size()-1];
                lows = ~p;
                m_offer = 1'b1;
                m_last  = p;
                m_none  = ($countones(lows) == 0);
                m_err   = ($countones(lows) > 1);
                m_sw    = ($countones(lows) == 1) ? 3'($clog2(lows)) : 3'd0;
            end
            if (enable) begin
                hist.push_back(led);
                if (hist.size() > N) void'(hist.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && bus.valid && bus.ready) acc_q.push_back(bus.switch);
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        do_reset();
        checks++;
        if ({bus.valid, bus.switch, bus.none, bus.err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", {bus.valid, bus.switch, bus.none, bus.err}, 6'b0);
        end
        bus.ready = 1'b1;
        led = 8'hFF;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.valid) seen++;
            checks++;
            if ({bus.valid, bus.switch, bus.none, bus.err} !== {m_offer, m_sw, m_none, m_err}) begin
                errors++;
                $display("FAIL reset_idle got=%b exp=%b", {bus.valid, bus.switch, bus.none, bus.err}, {m_offer, m_sw, m_none, m_err});
            end
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_event got=%0d exp=0", seen);
        end
    endtask

    task automatic test_latency();
        int seen;
        bus.ready = 1'b1;
        led = 8'hF7;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            checks++;
            if (bus.valid !== (e == 5)) begin
                errors++;
                $display("FAIL latency_edge%0d got=%b exp=%b", e, bus.valid, (e == 5));
            end
        end
        checks++;
        if ({bus.switch, bus.none, bus.err} !== {3'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL latency_code got=%b exp=%b", {bus.switch, bus.none, bus.err}, {3'd3, 2'b00});
        end
        seen = 0;
        repeat (31) begin
            @(negedge clk);
            if (bus.valid) seen++;
            checks++;
            if ({bus.valid, bus.switch, bus.none, bus.err} !== {m_offer, m_sw, m_none, m_err}) begin
                errors++;
                $display("FAIL latency_model got=%b exp=%b", {bus.valid, bus.switch, bus.none, bus.err}, {m_offer, m_sw, m_none, m_err});
            end
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL latency_no_repeat got=%0d exp=0", seen);
        end
    endtask

    task automatic test_glitch();
        int seen;
        int n;
        do_reset();
        bus.ready = 1'b1;
        led = 8'hEF;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.valid) seen++;
        end
        led = 8'hFF;
        repeat (10) begin
            @(negedge clk);
            if (bus.valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL glitch_no_event got=%0d exp=0", seen);
        end
        led = 8'hFE;
        n = 0;
        while (!bus.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL glitch_latency got=%0d exp=5", n);
        end
        checks++;
        if ({bus.valid, bus.switch, bus.none, bus.err} !== {1'b1, 3'd0, 2'b00}) begin
            errors++;
            $display("FAIL glitch_event got=%b exp=%b", {bus.valid, bus.switch, bus.none, bus.err}, {1'b1, 3'd0, 2'b00});
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n;
        bus.ready = 1'b0;
        led = 8'h7F;
        n = 0;
        while (!bus.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        led = 8'hFE;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({bus.valid, bus.switch} !== {1'b1, 3'd7}) begin
                errors++;
                $display("FAIL bp_hold%0d got=%b exp=%b", i, {bus.valid, bus.switch}, {1'b1, 3'd7});
            end
            @(negedge clk);
        end
        bus.ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_gap got=%b exp=0", bus.valid);
        end
        @(negedge clk);
        checks++;
        if ({bus.valid, bus.switch} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL bp_next got=%b exp=%b", {bus.valid, bus.switch}, {1'b1, 3'd0});
        end
        @(negedge clk);
    endtask

    task automatic test_special();
        int n;
        bus.ready = 1'b1;
        led = 8'hF3;
        n = 0;
        while (!bus.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({bus.valid, bus.switch, bus.none, bus.err} !== {1'b1, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL special_err got=%b exp=%b", {bus.valid, bus.switch, bus.none, bus.err}, 6'b100001);
        end
        @(negedge clk);
        led = 8'hFF;
        n = 0;
        while (!bus.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({bus.valid, bus.switch, bus.none, bus.err} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL special_none got=%b exp=%b", {bus.valid, bus.switch, bus.none, bus.err}, 6'b100010);
        end
        @(negedge clk);
        acc_q.delete();
        for (int c = 0; c < 8; c++) begin
            logic [7:0] one;
            one = 8'd1;
            led = 8'hFF - (one << c);
            n = 0;
            while (acc_q.size() < c + 1 && n < 80) begin
                bus.ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
                checks++;
                if ({bus.valid, bus.switch, bus.none, bus.err} !== {m_offer, m_sw, m_none, m_err}) begin
                    errors++;
                    $display("FAIL sweep_model got=%b exp=%b", {bus.valid, bus.switch, bus.none, bus.err}, {m_offer, m_sw, m_none, m_err});
                end
            end
        end
        checks++;
        if (acc_q.size() !== 8) begin
            errors++;
            $display("FAIL sweep_count got=%0d exp=8", acc_q.size());
        end
        foreach (acc_q[i]) begin
            checks++;
            if (acc_q[i] !== 3'(i)) begin
                errors++;
                $display("FAIL sweep_order%0d got=%0d exp=%0d", i, acc_q[i], i);
            end
        end
        bus.ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_control();
        int seen;
        int n;
        do_reset();
        bus.ready = 1'b1;
        enable = 1'b0;
        led = 8'hDF;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL ctl_frozen got=%0d exp=0", seen);
        end
        enable = 1'b1;
        n = 0;
        while (!bus.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({n, bus.switch} !== {32'd5, 3'd5}) begin
            errors++;
            $display("FAIL ctl_resume got=%0d/%0d exp=5/5", n, bus.switch);
        end
        @(negedge clk);
        bus.ready = 1'b0;
        led = 8'hBF;
        n = 0;
        while (!bus.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.valid, bus.switch, bus.none, bus.err} !== 6'b0) begin
            errors++;
            $display("FAIL ctl_rst_offer got=%b exp=%b", {bus.valid, bus.switch, bus.none, bus.err}, 6'b0);
        end
        rst = 1'b0;
        repeat (10) begin
            bus.ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({bus.valid, bus.switch, bus.none, bus.err} !== {m_offer, m_sw, m_none, m_err}) begin
                errors++;
                $display("FAIL ctl_model got=%b exp=%b", {bus.valid, bus.switch, bus.none, bus.err}, {m_offer, m_sw, m_none, m_err});
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 60; s++) begin
            int r;
            logic [7:0] one;
            one = 8'd1;
            r = int'($urandom_range(0, 9));
            if (r < 8)       led = 8'hFF - (one << r);
            else if (r == 8) led = 8'hFF;
            else             led = 8'($urandom);
            repeat ($urandom_range(1, 8)) begin
                bus.ready = 1'($urandom_range(0, 1));
                enable    = ($urandom_range(0, 7) != 0);
                @(negedge clk);
                checks++;
                if ({bus.valid, bus.switch, bus.none, bus.err} !== {m_offer, m_sw, m_none, m_err}) begin
                    errors++;
                    $display("FAIL random_model got=%b exp=%b", {bus.valid, bus.switch, bus.none, bus.err}, {m_offer, m_sw, m_none, m_err});
                end
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        led       = 8'hFF;
        bus.ready = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_backpressure();
        test_special();
        test_control();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
